// File: rtl/data_writer.sv
// Stores bytes strobed in by a UART receiver into a byte-wide RAM, one write
// per rising edge of Rx_tick, and raises fin once NUM_BYTES bytes are stored.
module data_writer #(
  parameter int ADDR_W    = 16,
  parameter int NUM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        Din,
  input  logic              Rx_tick,
  output logic              Wen,
  output logic [ADDR_W-1:0] Addr,
  output logic [7:0]        Dout,
  output logic              fin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The count is one bit wider than Addr so NUM_BYTES = 2**ADDR_W is reachable.
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(NUM_BYTES);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t            state_q;
  logic              rx_q;
  logic              wen_q;
  logic              fin_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              byte_event;

  assign byte_event = Rx_tick & ~rx_q;
  assign count_d    = count_q + COUNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rx_q    <= 1'b0;
      wen_q   <= 1'b0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      count_q <= '0;
    end else begin
      rx_q <= Rx_tick;
      case (state_q)
        IDLE: begin
          wen_q <= 1'b0;
          if (byte_event) begin
            dout_q  <= Din;
            wen_q   <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // Events arriving during the write cycle are dropped on purpose.
          wen_q   <= 1'b0;
          count_q <= count_d;
          if (count_d == LAST_COUNT) begin
            fin_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_q + ADDR_ONE;
            state_q <= IDLE;
          end
        end
        DONE: begin
          wen_q <= 1'b0;
          fin_q <= 1'b1;
        end
        default: begin
          wen_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Wen  = wen_q;
  assign Addr = addr_q;
  assign Dout = dout_q;
  assign fin  = fin_q;

endmodule

// File: tb/tb_data_writer.sv
// Directed bench for data_writer: a NUM_BYTES=4 instance for the protocol cases
// and a full-range instance (NUM_BYTES = 2**ADDR_W) for the top-address boundary.
module tb_data_writer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [7:0]  a_din;
  logic        a_tick;
  logic        a_wen;
  logic [15:0] a_addr;
  logic [7:0]  a_dout;
  logic        a_fin;

  logic [7:0]  b_din;
  logic        b_tick;
  logic        b_wen;
  logic [9:0]  b_addr;
  logic [7:0]  b_dout;
  logic        b_fin;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_writer #(.ADDR_W(16), .NUM_BYTES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .Din(a_din), .Rx_tick(a_tick),
    .Wen(a_wen), .Addr(a_addr), .Dout(a_dout), .fin(a_fin)
  );

  // Full-range case at a smaller width keeps the run short; the boundary is the same.
  data_writer #(.ADDR_W(10), .NUM_BYTES(1024)) dut_b (
    .clk(clk), .rst_n(rst_n), .Din(b_din), .Rx_tick(b_tick),
    .Wen(b_wen), .Addr(b_addr), .Dout(b_dout), .fin(b_fin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_clear(input string tag);
    chk({tag, "_wen"},  {31'd0, a_wen}, 32'd0);
    chk({tag, "_addr"}, {16'd0, a_addr}, 32'd0);
    chk({tag, "_dout"}, {24'd0, a_dout}, 32'd0);
    chk({tag, "_fin"},  {31'd0, a_fin}, 32'd0);
  endtask

  // Called just after a negedge. Raises Rx_tick for 'hold' cycles, scrambles Din
  // right after the event edge, and counts Wen pulses over the whole window.
  task automatic send_a(input string tag, input logic [7:0] d, input int hold,
                        input logic [15:0] exp_addr, input logic exp_write,
                        input logic exp_fin_after);
    int pulses;
    pulses = 0;
    a_din  = d;
    a_tick = 1'b1;
    @(negedge clk);
    pulses += int'(a_wen);
    chk({tag, "_wen"},  {31'd0, a_wen}, {31'd0, exp_write});
    chk({tag, "_addr"}, {16'd0, a_addr}, {16'd0, exp_addr});
    if (exp_write) begin
      chk({tag, "_dout"}, {24'd0, a_dout}, {24'd0, d});
      chk({tag, "_fin_during"}, {31'd0, a_fin}, 32'd0);
    end
    a_din = ~d;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      pulses += int'(a_wen);
    end
    a_tick = 1'b0;
    @(negedge clk);
    pulses += int'(a_wen);
    chk({tag, "_fin_after"}, {31'd0, a_fin}, {31'd0, exp_fin_after});
    if (exp_write) chk({tag, "_dout_hold"}, {24'd0, a_dout}, {24'd0, d});
    repeat (2) begin
      @(negedge clk);
      pulses += int'(a_wen);
    end
    chk({tag, "_pulses"}, 32'(pulses), {31'd0, exp_write});
    $display("txn %s din=%02h hold=%0d wen_pulses=%0d addr=%0h dout=%02h fin=%0b",
             tag, d, hold, pulses, a_addr, a_dout, a_fin);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_a_clear(tag);
    @(negedge clk);
    chk_a_clear({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int b_pulses;
    int b_errs_before;
    rst_n  = 1'b0;
    a_din  = 8'h00;
    a_tick = 1'b0;
    b_din  = 8'h00;
    b_tick = 1'b0;

    // Reset held while Rx_tick toggles: outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_tick = ~a_tick;
      b_tick = ~b_tick;
      chk_a_clear($sformatf("rst%0d", i));
    end
    a_tick = 1'b0;
    b_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_a_clear("rst_release");

    // Single byte.
    send_a("single", 8'h68, 1, 16'd0, 1'b1, 1'b0);
    pulse_reset("rst_after_single");

    // Four bytes, then a fifth tick that must be ignored.
    send_a("four0", 8'h68, 1, 16'd0, 1'b1, 1'b0);
    send_a("four1", 8'h01, 1, 16'd1, 1'b1, 1'b0);
    send_a("four2", 8'hA5, 1, 16'd2, 1'b1, 1'b0);
    send_a("four3", 8'hFF, 1, 16'd3, 1'b1, 1'b1);
    send_a("fifth", 8'h55, 1, 16'd3, 1'b0, 1'b1);
    chk("fifth_dout", {24'd0, a_dout}, 32'h0000_00FF);
    pulse_reset("rst_after_done");

    // Long tick counts once; Din change after the event is ignored.
    send_a("long", 8'h3C, 5, 16'd0, 1'b1, 1'b0);

    // Mid-stream reset after two writes restarts at address 0.
    send_a("mid1", 8'h11, 1, 16'd1, 1'b1, 1'b0);
    pulse_reset("rst_mid");
    send_a("post0", 8'hA0, 1, 16'd0, 1'b1, 1'b0);
    send_a("post1", 8'hA1, 2, 16'd1, 1'b1, 1'b0);
    send_a("post2", 8'hA2, 1, 16'd2, 1'b1, 1'b0);
    send_a("post3", 8'hA3, 3, 16'd3, 1'b1, 1'b1);

    // Full range on instance B: ticks every 2 cycles, the tightest legal spacing.
    b_pulses      = 0;
    b_errs_before = failures;
    for (int i = 0; i < 1024; i++) begin
      b_din  = 8'(i);
      b_tick = 1'b1;
      @(negedge clk);
      b_pulses += int'(b_wen);
      chk($sformatf("full_addr%0d", i), {22'd0, b_addr}, 32'(i));
      b_tick = 1'b0;
      @(negedge clk);
      b_pulses += int'(b_wen);
    end
    chk("full_pulses", 32'(b_pulses), 32'd1024);
    chk("full_fin", {31'd0, b_fin}, 32'd1);
    chk("full_last_addr", {22'd0, b_addr}, 32'h3FF);
    chk("full_last_dout", {24'd0, b_dout}, 32'hFF);
    b_tick = 1'b1;
    @(negedge clk);
    chk("full_extra_wen", {31'd0, b_wen}, 32'd0);
    b_tick = 1'b0;
    @(negedge clk);
    chk("full_extra_addr", {22'd0, b_addr}, 32'h3FF);
    chk("full_extra_fin", {31'd0, b_fin}, 32'd1);
    $display("txn full_range bytes=1024 wen_pulses=%0d last_addr=%0h fin=%0b new_failures=%0d",
             b_pulses, b_addr, b_fin, failures - b_errs_before);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_writer.md
Name: data_writer

Overview:
- Takes bytes delivered by a UART receiver (Din qualified by Rx_tick) and writes them sequentially into a byte-wide memory through a simple write port (Wen/Addr/Dout).
- Writes start at address 0 and end after NUM_BYTES bytes, when fin is asserted.
- Sits between uart_rx and the image/data RAM of the downsampling processor; fin tells downstream logic the buffer is loaded.

Parameters:
- ADDR_W, 16, width of Addr.
- NUM_BYTES, 65536, number of bytes to store before fin; legal range 1 .. 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Din  in  8  received byte; valid while Rx_tick is high.
- Rx_tick  in  1  byte-valid strobe from UART receiver, synchronous to clk; may stay high for one or more cycles per byte.
- Wen  out  1  memory write enable; one-cycle pulse per stored byte.
- Addr  out  ADDR_W  memory write address.
- Dout  out  8  memory write data.
- fin  out  1  high when NUM_BYTES bytes have been written.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, Wen=0, Addr=0, Dout=0, fin=0, internal byte count=0, Rx_tick history register=0.
- Edge detection: register rx_d <= Rx_tick every cycle. A byte event is Rx_tick=1 and rx_d=0, sampled at a clock edge.
  - A multi-cycle-high Rx_tick counts as exactly one byte.
  - A new byte needs Rx_tick to return low for at least one sampled cycle.
- States:
  - IDLE: on a byte event, latch Din into Dout, go to WRITE.
  - WRITE: lasts 1 cycle. Wen=1, Addr holds the current write address, Dout holds the latched byte. On exit, increment count.
    - If count then equals NUM_BYTES, go to DONE.
    - Otherwise increment Addr and return to IDLE.
  - DONE: fin=1 and Wen=0. Addr holds the last written address (NUM_BYTES-1). Byte events are ignored. Leave DONE only by reset.
- Latency: Wen is high in the clock cycle immediately after the edge where the byte event was sampled.
- Dout and Addr are stable for the whole Wen-high cycle. The memory samples them at the clock edge that ends that cycle.
- Dout is latched at the event edge; later changes of Din do not affect the write in progress.
- A byte event occurring during the WRITE cycle is ignored. Rx_tick spacing from the UART is far larger than 2 cycles, so this is acceptable.
- Wrap-around: with NUM_BYTES = 2**ADDR_W, the last write is at address 2**ADDR_W-1. Addr does not wrap to 0; it stays at the top address in DONE.
- fin rises in the cycle after the last Wen pulse and stays high until rst_n is asserted.
- Reset mid-operation: asserting rst_n aborts immediately and clears all outputs. After reset release, the next byte event writes to address 0.
- Wen is never high in IDLE or DONE. Wen is never high for two consecutive cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 while toggling Rx_tick, then release -> Wen=0, Addr=0, Dout=0, fin=0 throughout reset.
- Single byte, NUM_BYTES=4: Din=8'h68, Rx_tick high one cycle -> one Wen pulse in the next cycle with Addr=0, Dout=8'h68; fin stays 0.
- Four bytes, NUM_BYTES=4: four 1-cycle ticks 4 cycles apart with Din=8'h68,8'h01,8'hA5,8'hFF.
  - Expect Wen pulses at Addr=0,1,2,3 carrying those data values.
  - Expect fin=1 the cycle after the 4th write.
  - A 5th tick produces no Wen, and Addr stays 3.
- Long tick: Rx_tick held high 5 cycles -> exactly one Wen pulse. Din changed during the high period does not alter Dout for that write.
- Reset mid-stream, NUM_BYTES=4: after 2 writes assert rst_n=0 for 1 cycle -> outputs clear. The next tick writes Addr=0; fin appears only after 4 further writes.
- Full range, NUM_BYTES=65536: after 65536 ticks the last write has Addr=16'hFFFF, then fin=1 and Addr remains 16'hFFFF.
